// File: rtl/ram_dma_engine_pkg.sv
// rtl/ram_dma_engine_pkg.sv - shared widths, modes and state encoding for the RAM DMA engine
package ram_dma_pkg;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_FILL,
        ST_DONE
    } state_e;
endpackage

// File: rtl/ram_dma_engine_if.sv
// rtl/ram_dma_engine_if.sv - host command and RAM port bundle for the RAM DMA engine
interface ram_dma_engine_if #(
    parameter int ADDR_W = ram_dma_pkg::ADDR_W,
    parameter int DATA_W = ram_dma_pkg::DATA_W,
    parameter int LEN_W  = ADDR_W + 1
);
    logic              start_i;
    logic              mode_i;
    logic [ADDR_W-1:0] src_i;
    logic [ADDR_W-1:0] dst_i;
    logic [LEN_W-1:0]  len_i;
    logic [DATA_W-1:0] fill_val_i;
    logic              busy_o;
    logic              done_o;
    logic [LEN_W-1:0]  count_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_din_o;
    logic [DATA_W-1:0] mem_dout_i;

    modport slave (
        input  start_i, mode_i, src_i, dst_i, len_i, fill_val_i, mem_dout_i,
        output busy_o, done_o, count_o, mem_addr_o, mem_we_o, mem_din_o
    );

    modport master (
        output start_i, mode_i, src_i, dst_i, len_i, fill_val_i, mem_dout_i,
        input  busy_o, done_o, count_o, mem_addr_o, mem_we_o, mem_din_o
    );
endinterface

// File: rtl/ram_dma_engine.sv
// rtl/ram_dma_engine.sv - copy/fill engine owning the single-port RAM while a command runs
module ram_dma_engine #(
    parameter int ADDR_W = ram_dma_pkg::ADDR_W,
    parameter int DATA_W = ram_dma_pkg::DATA_W,
    parameter int LEN_W  = ADDR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    ram_dma_engine_if.slave    bus
);
    import ram_dma_pkg::*;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] fill_q, fill_d;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_din;
    logic [LEN_W-1:0]  idx_inc;
    logic              last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            fill_q  <= fill_d;
        end
    end

    // idx is LEN_W wide so a 64-byte command terminates; only its low bits form the address
    assign idx_inc = idx_q + LEN_W'(1);
    assign last    = (idx_inc == len_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        mode_d   = mode_q;
        src_d    = src_q;
        dst_d    = dst_q;
        len_d    = len_q;
        fill_d   = fill_q;
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_din  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    mode_d  = bus.mode_i;
                    src_d   = bus.src_i;
                    dst_d   = bus.dst_i;
                    len_d   = bus.len_i;
                    fill_d  = bus.fill_val_i;
                    idx_d   = '0;
                    count_d = '0;
                    if (bus.len_i == '0)
                        state_d = ST_DONE;
                    else if (bus.mode_i == MODE_COPY)
                        state_d = ST_RD;
                    else
                        state_d = ST_FILL;
                end
            end
            ST_RD: begin
                mem_addr = src_q + idx_q[ADDR_W-1:0];
                state_d  = ST_WR;
            end
            ST_WR: begin
                mem_addr = dst_q + idx_q[ADDR_W-1:0];
                mem_we   = 1'b1;
                mem_din  = bus.mem_dout_i;
                idx_d    = idx_inc;
                count_d  = count_q + LEN_W'(1);
                state_d  = last ? ST_DONE : ST_RD;
            end
            ST_FILL: begin
                mem_addr = dst_q + idx_q[ADDR_W-1:0];
                mem_we   = 1'b1;
                mem_din  = fill_q;
                idx_d    = idx_inc;
                count_d  = count_q + LEN_W'(1);
                state_d  = last ? ST_DONE : ST_FILL;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy_o     = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_FILL);
    assign bus.done_o     = (state_q == ST_DONE);
    assign bus.count_o    = count_q;
    assign bus.mem_addr_o = mem_addr;
    assign bus.mem_we_o   = mem_we;
    assign bus.mem_din_o  = mem_din;
endmodule

// File: tb/tb_ram_dma_engine.sv
// tb/tb_ram_dma_engine.sv - scoreboard bench for the RAM DMA engine with a 64x8 RAM model
module tb_ram_dma_engine;
    import ram_dma_pkg::*;

    typedef struct {
        int cnt;
        int busy;
    } exp_t;

    logic clk;
    logic rst;
    logic preload;
    logic [7:0] mem [64];
    logic [7:0] ram_dout;

    int vectors;
    int miscompares;
    int done_cnt;
    int we_cnt;
    int busy_run;
    exp_t exp_q[$];

    ram_dma_engine_if dut_if ();

    ram_dma_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
        end else if (dut_if.mem_we_o) begin
            mem[dut_if.mem_addr_o] <= dut_if.mem_din_o;
        end else begin
            ram_dout <= mem[dut_if.mem_addr_o];
        end
    end
    assign dut_if.mem_dout_i = ram_dout;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (dut_if.mem_we_o) we_cnt++;
            if (dut_if.busy_o) busy_run++;
            if (dut_if.done_o) begin
                exp_t e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_count", int'(dut_if.count_o), e.cnt);
                    chk("busy_cycles", busy_run, e.busy);
                    chk("busy_at_done", int'(dut_if.busy_o), 0);
                end
                busy_run = 0;
            end
        end
    end

    task automatic do_preload();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
    endtask

    task automatic issue(input logic m, input int s, input int d, input int l, input int fv,
                         input int exp_cnt, input int exp_busy, input int exp_lat,
                         input bit interfere);
        exp_t e;
        int lat;
        e.cnt  = exp_cnt;
        e.busy = exp_busy;
        exp_q.push_back(e);
        @(negedge clk);
        dut_if.start_i    = 1'b1;
        dut_if.mode_i     = m;
        dut_if.src_i      = 6'(s);
        dut_if.dst_i      = 6'(d);
        dut_if.len_i      = 7'(l);
        dut_if.fill_val_i = 8'(fv);
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            dut_if.start_i    = 1'b0;
            dut_if.mode_i     = ~m;
            dut_if.src_i      = 6'd40;
            dut_if.dst_i      = 6'd48;
            dut_if.len_i      = 7'd2;
            dut_if.fill_val_i = 8'h5A;
            if (interfere && lat == 3) dut_if.start_i = 1'b1;
            #1;
            if (dut_if.done_o) break;
        end
        chk("done_latency", lat, exp_lat);
    endtask

    initial begin
        int d0;
        int w0;
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        we_cnt      = 0;
        busy_run    = 0;
        preload     = 1'b0;
        rst         = 1'b1;
        dut_if.start_i    = 1'b0;
        dut_if.mode_i     = MODE_COPY;
        dut_if.src_i      = '0;
        dut_if.dst_i      = '0;
        dut_if.len_i      = '0;
        dut_if.fill_val_i = '0;
        #1;
        chk("rst_busy", int'(dut_if.busy_o), 0);
        chk("rst_done", int'(dut_if.done_o), 0);
        chk("rst_we", int'(dut_if.mem_we_o), 0);
        chk("rst_addr", int'(dut_if.mem_addr_o), 0);
        chk("rst_din", int'(dut_if.mem_din_o), 0);
        chk("rst_count", int'(dut_if.count_o), 0);
        @(negedge clk) rst = 1'b0;
        do_preload();

        // copy 0..3 -> 16..19
        issue(MODE_COPY, 0, 16, 4, 0, 4, 8, 9, 1'b0);
        for (int i = 16; i < 20; i++) chk($sformatf("copy_mem%0d", i), int'(mem[i]), i - 16);
        for (int i = 0; i < 16; i++) chk($sformatf("copy_src%0d", i), int'(mem[i]), i);
        chk("count_holds", int'(dut_if.count_o), 4);

        // fill wraps 63 -> 0
        issue(MODE_FILL, 0, 60, 8, 8'hA5, 8, 8, 9, 1'b0);
        for (int i = 60; i < 64; i++) chk($sformatf("fill_mem%0d", i), int'(mem[i]), 8'hA5);
        for (int i = 0; i < 4; i++) chk($sformatf("fill_mem%0d", i), int'(mem[i]), 8'hA5);
        chk("fill_mem4", int'(mem[4]), 4);

        // zero length
        w0 = we_cnt;
        issue(MODE_COPY, 5, 30, 0, 0, 0, 0, 1, 1'b0);
        @(negedge clk);
        chk("len0_we", we_cnt - w0, 0);

        // restart ignored while busy
        d0 = done_cnt;
        issue(MODE_COPY, 8, 24, 4, 0, 4, 8, 9, 1'b1);
        repeat (4) @(negedge clk);
        chk("single_done", done_cnt - d0, 1);
        for (int i = 24; i < 28; i++) chk($sformatf("busy_mem%0d", i), int'(mem[i]), i - 16);
        chk("ignored_mem48", int'(mem[48]), 48);
        chk("ignored_mem49", int'(mem[49]), 49);

        // abort by reset during RD of byte 3
        d0 = done_cnt;
        @(negedge clk);
        dut_if.start_i = 1'b1;
        dut_if.mode_i  = MODE_COPY;
        dut_if.src_i   = 6'd32;
        dut_if.dst_i   = 6'd40;
        dut_if.len_i   = 7'd6;
        @(negedge clk) dut_if.start_i = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(dut_if.busy_o), 0);
        chk("abort_we", int'(dut_if.mem_we_o), 0);
        @(negedge clk) rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        for (int i = 40; i < 43; i++) chk($sformatf("abort_mem%0d", i), int'(mem[i]), i - 8);
        chk("abort_mem44", int'(mem[44]), 44);
        chk("abort_mem45", int'(mem[45]), 45);

        // overlapping copy replicates, then full-size self copy
        do_preload();
        issue(MODE_COPY, 0, 1, 4, 0, 4, 8, 9, 1'b0);
        issue(MODE_COPY, 0, 0, 64, 0, 64, 128, 129, 1'b0);
        for (int i = 0; i < 64; i++)
            chk($sformatf("ovl_mem%0d", i), int'(mem[i]), (i <= 4) ? 0 : i);
        chk("full_count", int'(dut_if.count_o), 64);

        chk("pending_expect", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
